stage50: RTL
============

# stage50

Output buffering stage of the router pipeline, directly downstream of the stage that merges system and normal flits and stamps the checksum. It accepts one checksummed flit per cycle without upstream handshake, holds flits in a small FIFO plus an output register, and presents them to the link transmitter over a valid/ready handshake. Overflowing flits are dropped and counted; back-pressure is signalled upstream through `in_ready`.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries behind the output register; power of two, at least 2.
- `CNT_WIDTH`, 8, width of the saturating statistics counters.

Ports:
- `nocclk`  in  1  clock; everything is on the rising edge.
- `rst`  in  1  reset: one clock; reset is asynchronous and active-high.
- `in_flit_valid`  in  1  upstream flit present this cycle.
- `in_flit`  in  types::flit_t  checksummed flit from the upstream merge stage.
- `in_ready`  out  1  registered; 1 while at least one slot is free, counting the output register and the FIFO.
- `out_flit_valid`  out  1  output register holds a flit.
- `out_flit`  out  types::flit_t  head flit; stable while `out_flit_valid && !out_flit_ready`.
- `out_flit_ready`  in  1  transmitter accepts the flit.
- `occupancy`  out  $clog2(DEPTH+1)+1  flits held, output register included.
- `drop_count`  out  CNT_WIDTH  saturating count of flits dropped because the stage was full.
- `cksum_err_count`  out  CNT_WIDTH  saturating count of checksum-rejected flits. Present only with the macro.

## Operation
- Transfer out: `out_flit_valid && out_flit_ready` at a clock edge.
- Accept in: `in_flit_valid`, a free slot, and the flit is not rejected by the checksum check.
  - A slot is free when `occupancy < DEPTH+1`, or when a transfer out happens in the same cycle.
- On accept, the destination depends on state:
  - Output register empty, or being drained with an empty FIFO: the flit loads directly into the output register (bypass).
  - Otherwise: the flit is written to the FIFO tail.
- On a transfer out: the output register loads the FIFO head if the FIFO is non-empty. If it is empty, the register loads the bypass flit if one is accepted, or goes invalid.
- Output-register state machine:
  - EMPTY -> FULL on accept.
  - FULL -> FULL on a transfer out with a refill available.
  - FULL -> EMPTY on a transfer out with nothing to refill.
- Overflow: `in_flit_valid` with no free slot drops the flit. The dropped flit never appears on `out_flit`, and `drop_count` increments, saturating at all-ones.
- Simultaneous accept and transfer out with a full FIFO: both happen, and occupancy is unchanged.
- Pointers: read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. The full/empty distinction comes from the occupancy counter, not pointer equality.
- Ordering: flits leave in strict acceptance order; system and normal flits are not distinguished.
- `in_ready` is computed from the next-state occupancy: 1 when next occupancy < DEPTH+1.

## Timing
- Latency: a flit accepted at edge N with the stage empty is visible on `out_flit`/`out_flit_valid` after edge N; one cycle, no combinational path from `in_flit` to `out_flit`.
- Throughput: one flit per cycle in and out, sustained, while `out_flit_ready` stays high.
- `in_ready` is registered, so it lags by one cycle. Upstream may therefore present one flit after `in_ready` falls. That flit is accepted if a transfer out frees a slot in the same cycle; otherwise it is dropped and counted.
- Reset, asynchronous:
  - `out_flit_valid`=0, `out_flit`=0, `in_ready`=1, `occupancy`=0.
  - Pointers=0, `drop_count`=0, `cksum_err_count`=0.
  - Reset mid-transfer discards all held flits; the first accept after release behaves as the empty case.

## Configuration
- `STAGE50_CHECKSUM_CHECK_EN` defined:
  - Every valid `in_flit` is verified combinationally before the accept decision.
  - A failing flit is not accepted, occupies no slot, and increments `cksum_err_count`, saturating.
  - Only a flit that would otherwise be accepted increments `cksum_err_count`; a failing flit arriving while full increments `drop_count` only.
- Not defined: no check is made, and the `cksum_err_count` port and its logic are absent.

## Structure
- Package `types`: `flit_t` and checksum field positions, already present.
- Package `types` also gets a new `STAGE50_DEFAULT_DEPTH`.
- Sub-module `sync_fifo`: parameterised by width and depth, with push/pop/full/empty. `stage50` owns the output register, bypass, counters and `in_ready`.
- The checksum verification reuses the existing combinational checksum logic, recomputing the checksum over `in_flit` and comparing it with the carried field.

## Test plan
- Single flit: reset, then `in_flit_valid`=1 with flit A for one cycle, `out_flit_ready`=1 -> `out_flit`=A with valid high exactly one cycle after the accept edge, then valid low; `occupancy` back to 0.
- Back-pressure fill: `out_flit_ready`=0, push flits 1..7 on consecutive cycles with DEPTH=4:
  - Flits 1..5 are held.
  - `in_ready` falls after the 5th accept.
  - Flits 6 and 7 are dropped and `drop_count`=2.
  - Raising ready drains 1..5 in order, one per cycle.
- Streaming at full with DEPTH=4: `occupancy`=5 and push plus pop every cycle for 10 cycles -> no drops, order preserved, `occupancy` stays 5.
- Saturation: with CNT_WIDTH=8, force 300 overflow drops -> `drop_count`=255 and it stays there.
- Reset mid-operation: assert `rst` asynchronously, between clock edges, with 3 flits held -> outputs take their reset values immediately; after release, flit B passes with 1-cycle latency.
- Checksum, macro defined: push a good flit, a flit with a corrupted checksum, then a good flit -> only the two good flits appear, and `cksum_err_count`=1.

Source files
------------

// File: rtl/types.sv
// types: shared flit format, checksum field layout and the checksum function.
package types;
  localparam int FLIT_W    = 32;
  localparam int CKSUM_W   = 8;
  localparam int CKSUM_LSB = 0;
  localparam int BODY_LSB  = CKSUM_LSB + CKSUM_W;
  localparam int BODY_W    = FLIT_W - BODY_LSB;
  localparam int STAGE50_DEFAULT_DEPTH = 4;
  typedef struct packed {
    logic              is_sys;
    logic [22:0]       data;
    logic [CKSUM_W-1:0] cksum;
  } flit_t;
  typedef enum logic {OREG_EMPTY, OREG_FULL} oreg_state_t;
  // Byte-wise XOR over the flit body (everything above the checksum field).
  function automatic logic [CKSUM_W-1:0] cksum_calc(input flit_t f);
    logic [BODY_W-1:0] b;
    b = {f.is_sys, f.data};
    return b[23:16] ^ b[15:8] ^ b[7:0];
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: power-of-two circular FIFO with occupancy-based full/empty.
// Ports: clk, rst (async, active-high), i_push/i_wr_data write the tail,
// i_pop advances the head, o_rd_data shows the head, o_full/o_empty status.
// Push while full is legal only together with a pop in the same cycle.
module sync_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_wr_data,
  output logic [W-1:0] o_rd_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + PW'(1);
      if (i_pop) r_rp <= r_rp + PW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wp] <= i_wr_data;
  end
  assign o_rd_data = r_mem[r_rp];
  assign o_full    = r_cnt == CW'(DEPTH);
  assign o_empty   = r_cnt == '0;
endmodule

// File: rtl/stage50.sv
// stage50: router output buffer -- output register plus FIFO with valid/ready egress.
// Ports: nocclk, rst (async, active-high); in_flit_valid/in_flit from the merge
// stage (no handshake), in_ready registered back-pressure; out_flit_valid/
// out_flit/out_flit_ready to the link transmitter; occupancy counts held flits
// including the output register; drop_count saturates on overflow drops.
// Option STAGE50_CHECKSUM_CHECK_EN: reject flits whose carried checksum does
// not match, counting them in the extra cksum_err_count port.
module stage50
  import types::*;
#(
  parameter int DEPTH     = STAGE50_DEFAULT_DEPTH,
  parameter int CNT_WIDTH = 8
) (
  input  logic                      nocclk,
  input  logic                      rst,
  input  logic                      in_flit_valid,
  input  flit_t                     in_flit,
  output logic                      in_ready,
  output logic                      out_flit_valid,
  output flit_t                     out_flit,
  input  logic                      out_flit_ready,
  output logic [$clog2(DEPTH+1):0]  occupancy,
  output logic [CNT_WIDTH-1:0]      drop_count
`ifdef STAGE50_CHECKSUM_CHECK_EN
  ,
  output logic [CNT_WIDTH-1:0]      cksum_err_count
`endif
);
  localparam int OW = $clog2(DEPTH + 1) + 1;
  localparam logic [OW-1:0] SLOTS = OW'(DEPTH + 1);
  oreg_state_t          r_state;
  flit_t                r_out;
  logic [OW-1:0]        r_occ;
  logic                 r_in_ready;
  logic [CNT_WIDTH-1:0] r_drop;
  logic                 w_xfer;
  logic                 w_free;
  logic                 w_ck_ok;
  logic                 w_acc;
  logic                 w_bypass;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  flit_t                w_fifo_head;
  logic [OW-1:0]        w_occ_nxt;
  assign w_xfer = (r_state == OREG_FULL) && out_flit_ready;
  // A departing flit frees its slot in the same cycle.
  assign w_free = (r_occ < SLOTS) || w_xfer;
`ifdef STAGE50_CHECKSUM_CHECK_EN
  assign w_ck_ok = cksum_calc(in_flit) == in_flit.cksum;
`else
  assign w_ck_ok = 1'b1;
`endif
  assign w_acc    = in_flit_valid && w_free && w_ck_ok;
  // Bypass the FIFO when nothing older than this flit is still buffered.
  assign w_bypass = w_acc && ((r_state == OREG_EMPTY) || (w_xfer && w_fifo_empty));
  assign w_pop    = w_xfer && !w_fifo_empty;
  assign w_push   = w_acc && !w_bypass && (!w_fifo_full || w_pop);
  assign w_occ_nxt = r_occ + OW'(w_acc) - OW'(w_xfer);
  sync_fifo #(
    .W     ($bits(flit_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (nocclk),
    .rst       (rst),
    .i_push    (w_push),
    .i_pop     (w_pop),
    .i_wr_data (in_flit),
    .o_rd_data (w_fifo_head),
    .o_full    (w_fifo_full),
    .o_empty   (w_fifo_empty)
  );
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      r_state <= OREG_EMPTY;
      r_out   <= '0;
    end else begin
      if (w_pop) r_out <= w_fifo_head;
      else if (w_bypass) r_out <= in_flit;
      r_state <= (w_pop || w_bypass || (r_state == OREG_FULL && !w_xfer)) ? OREG_FULL : OREG_EMPTY;
    end
  end
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) begin
      r_occ      <= '0;
      r_in_ready <= 1'b1;
      r_drop     <= '0;
    end else begin
      r_occ      <= w_occ_nxt;
      r_in_ready <= w_occ_nxt < SLOTS;
      if (in_flit_valid && !w_free && r_drop != '1) r_drop <= r_drop + CNT_WIDTH'(1);
    end
  end
`ifdef STAGE50_CHECKSUM_CHECK_EN
  logic [CNT_WIDTH-1:0] r_cerr;
  // Only flits that had a slot count as checksum errors; full-stage drops win.
  always_ff @(posedge nocclk or posedge rst) begin
    if (rst) r_cerr <= '0;
    else if (in_flit_valid && w_free && !w_ck_ok && r_cerr != '1) r_cerr <= r_cerr + CNT_WIDTH'(1);
  end
  assign cksum_err_count = r_cerr;
`endif
  assign out_flit_valid = r_state == OREG_FULL;
  assign out_flit       = r_out;
  assign in_ready       = r_in_ready;
  assign occupancy      = r_occ;
  assign drop_count     = r_drop;
endmodule
